// File: rtl/score_ctrl.sv
// Game-flow controller: IDLE/PLAY/OVER sequencing, pipe-edge score increments and restart hold.
// Optional high-score tracking is enabled by defining SCORE_CTRL_HISCORE_EN.
module score_ctrl #(
  parameter int unsigned RESTART_HOLD = 100
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pipe_passed_i,
  input  logic       collision_i,
  input  logic [3:0] score_d0_i,
  input  logic [3:0] score_d1_i,
  input  logic [3:0] score_d2_i,
  input  logic [3:0] score_d3_i,
  output logic       score_en_o,
  output logic       score_rst_no,
  output logic [1:0] state_o,
  output logic [3:0] hi_d0_o,
  output logic [3:0] hi_d1_o,
  output logic [3:0] hi_d2_o,
  output logic [3:0] hi_d3_o,
  output logic       new_high_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pipe_q;
  logic        score_en_q, score_en_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] score_cur;
  logic        pipe_edge;
  logic        score_max;

  assign score_cur = {score_d3_i, score_d2_i, score_d1_i, score_d0_i};
  assign pipe_edge = pipe_passed_i & ~pipe_q;
  assign score_max = (score_cur == 16'h9999);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    score_en_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StPlay;
      end
      StPlay: begin
        // Collision wins over a simultaneous pipe edge.
        if (collision_i) begin
          state_d = StOver;
          timer_d = 16'(RESTART_HOLD);
        end else if (pipe_edge && !score_max) begin
          score_en_d = 1'b1;
        end
      end
      StOver: begin
        if (timer_q == 16'd0) begin
          if (start_i) state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pipe_q     <= 1'b0;
      score_en_q <= 1'b0;
      timer_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      pipe_q     <= pipe_passed_i;
      score_en_q <= score_en_d;
      timer_q    <= timer_d;
    end
  end

  assign score_en_o   = score_en_q;
  assign score_rst_no = (state_q != StIdle);
  assign state_o      = state_q;

`ifdef SCORE_CTRL_HISCORE_EN
  logic [15:0] hi_q, hi_d;
  logic        new_high_q, new_high_d;
  logic        over_first_q;

  // BCD digits with d3 as MSB order the same as plain binary.
  always_comb begin
    hi_d       = hi_q;
    new_high_d = new_high_q;
    if (state_q == StOver && over_first_q && score_cur > hi_q) begin
      hi_d       = score_cur;
      new_high_d = 1'b1;
    end
    if (state_q == StOver && state_d == StIdle) new_high_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q         <= 16'h0000;
      new_high_q   <= 1'b0;
      over_first_q <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      new_high_q   <= new_high_d;
      over_first_q <= (state_q == StPlay) && (state_d == StOver);
    end
  end

  assign hi_d0_o    = hi_q[3:0];
  assign hi_d1_o    = hi_q[7:4];
  assign hi_d2_o    = hi_q[11:8];
  assign hi_d3_o    = hi_q[15:12];
  assign new_high_o = new_high_q;
`else
  assign hi_d0_o    = 4'd0;
  assign hi_d1_o    = 4'd0;
  assign hi_d2_o    = 4'd0;
  assign hi_d3_o    = 4'd0;
  assign new_high_o = 1'b0;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: per-cycle score_en scoreboard plus state/high-score checks.
module tb_score_ctrl;

`ifdef SCORE_CTRL_HISCORE_EN
  localparam bit HiEn = 1'b1;
`else
  localparam bit HiEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, pipe_passed_i, collision_i;
  logic [15:0] score;
  logic        score_en_o, score_rst_no, new_high_o;
  logic [1:0]  state_o;
  logic [3:0]  hi_d0_o, hi_d1_o, hi_d2_o, hi_d3_o;
  logic [15:0] hi_all;

  int ncomp = 0;
  int nfail = 0;
  logic exp_q[$];

  assign hi_all = {hi_d3_o, hi_d2_o, hi_d1_o, hi_d0_o};

  score_ctrl #(.RESTART_HOLD(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .pipe_passed_i (pipe_passed_i),
    .collision_i   (collision_i),
    .score_d0_i    (score[3:0]),
    .score_d1_i    (score[7:4]),
    .score_d2_i    (score[11:8]),
    .score_d3_i    (score[15:12]),
    .score_en_o    (score_en_o),
    .score_rst_no  (score_rst_no),
    .state_o       (state_o),
    .hi_d0_o       (hi_d0_o),
    .hi_d1_o       (hi_d1_o),
    .hi_d2_o       (hi_d2_o),
    .hi_d3_o       (hi_d3_o),
    .new_high_o    (new_high_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] exp_hi(input logic [15:0] v);
    return HiEn ? v : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected score_en for the edge, compare after it.
  task automatic step(input logic p, input logic c, input logic s, input logic exp_en);
    logic e;
    pipe_passed_i = p;
    collision_i   = c;
    start_i       = s;
    exp_q.push_back(exp_en);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    chk("score_en", {31'd0, score_en_o}, {31'd0, e});
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; pipe_passed_i = 1'b0; collision_i = 1'b0; score = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_score_rst_n", 32'(score_rst_no), 32'd0);
    chk("rst_en", 32'(score_en_o), 32'd0);
    chk("rst_hi", 32'(hi_all), 32'd0);
    chk("rst_new_high", 32'(new_high_o), 32'd0);
    rst_ni = 1'b1;

    // Start, then three single-cycle pipe pulses.
    step(0, 0, 1, 0);
    chk("play_state", 32'(state_o), 32'd1);
    chk("play_score_rst_n", 32'(score_rst_no), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      step(0, 0, 0, 0);
    end

    // Held pipe: one pulse only.
    step(1, 0, 0, 1);
    for (int i = 0; i < 19; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Saturation at 9999.
    score = 16'h9999;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_state", 32'(state_o), 32'd1);

    // Collision together with a pipe edge at 0042.
    score = 16'h0042;
    step(1, 1, 0, 0);
    chk("coll_state", 32'(state_o), 32'd2);
    step(0, 0, 0, 0);
    chk("over1_hi", 32'(hi_all), 32'(exp_hi(16'h0042)));
    chk("over1_new_high", 32'(new_high_o), 32'(HiEn));
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("over_ignore_state", 32'(state_o), 32'd2);
    step(0, 0, 1, 0);
    chk("restart_state", 32'(state_o), 32'd0);
    chk("restart_new_high", 32'(new_high_o), 32'd0);
    chk("restart_hi_kept", 32'(hi_all), 32'(exp_hi(16'h0042)));
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("idle_state", 32'(state_o), 32'd0);

    // Asynchronous reset between edges with a pulse in flight.
    score = 16'h0003;
    step(0, 0, 1, 0);
    step(1, 0, 0, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_en", 32'(score_en_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_score_rst_n", 32'(score_rst_no), 32'd0);
    chk("arst_hi", 32'(hi_all), 32'd0);
    #2 rst_ni = 1'b1;
    step(0, 0, 0, 0);
    chk("post_arst_state", 32'(state_o), 32'd0);

    // Game A ends at 0012.
    step(0, 0, 1, 0);
    score = 16'h0012;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("gameA_hi", 32'(hi_all), 32'(exp_hi(16'h0012)));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("gameA_idle", 32'(state_o), 32'd0);

    // Game B ends at 0017; start held early is ignored during the hold.
    step(0, 0, 1, 0);
    score = 16'h0017;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("gameB_c1_state", 32'(state_o), 32'd2);
    chk("gameB_hi", 32'(hi_all), 32'(exp_hi(16'h0017)));
    chk("gameB_new_high", 32'(new_high_o), 32'(HiEn));
    step(0, 0, 1, 0);
    chk("gameB_c2_state", 32'(state_o), 32'd2);
    step(0, 0, 1, 0);
    chk("gameB_c3_state", 32'(state_o), 32'd2);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("gameB_c5_state", 32'(state_o), 32'd0);
    chk("gameB_score_rst_n", 32'(score_rst_no), 32'd0);
    chk("gameB_new_high_clr", 32'(new_high_o), 32'd0);
    chk("gameB_hi_kept", 32'(hi_all), 32'(exp_hi(16'h0017)));

    // Game C ends at 0005: high score unchanged.
    step(0, 0, 1, 0);
    score = 16'h0005;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("gameC_hi", 32'(hi_all), 32'(exp_hi(16'h0017)));
    chk("gameC_new_high", 32'(new_high_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter RESTART_HOLD, default 100: minimum cycles in OVER before start_i is honoured; legal range 0..65535.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start_i, input, 1: start/restart request (level).
REQ-005 SHALL have port pipe_passed_i, input, 1: pipe-cleared indication (level; may be held many cycles).
REQ-006 SHALL have port collision_i, input, 1: collision indication (level).
REQ-007 SHALL have ports score_d0_i..score_d3_i, input, 4 each: live BCD score from the score counter (d0 = ones).
REQ-008 SHALL have port score_en_o, output, 1: increment enable to the score counter.
REQ-009 SHALL have port score_rst_no, output, 1: synchronous active-low clear to the score counter.
REQ-010 SHALL have port state_o, output, 2: FSM state, IDLE=2'd0, PLAY=2'd1, OVER=2'd2; 2'd3 never driven.
REQ-011 SHALL have ports hi_d0_o..hi_d3_o, output, 4 each: high score, BCD.
REQ-012 SHALL have port new_high_o, output, 1: last game set a new high score.

Function
REQ-013 SHALL be a 3-state FSM: IDLE -> PLAY when start_i=1; PLAY -> OVER when collision_i=1; OVER -> IDLE when start_i=1 and hold timer expired.
REQ-014 SHALL drive score_rst_no=0 in every IDLE cycle, 1 in PLAY and OVER.
REQ-015 SHALL detect rising edges of pipe_passed_i with a registered previous value; held-high input yields exactly one increment.
REQ-016 SHALL register score_en_o: high for exactly one cycle, the cycle after a PLAY cycle containing a pipe edge with collision_i=0.
REQ-017 SHALL give collision priority: pipe edge and collision_i in the same cycle produce no increment.
REQ-018 SHALL saturate: no score_en_o pulse when score inputs read 9999 in the edge cycle.
REQ-019 SHALL ignore pipe_passed_i and collision_i in IDLE and OVER (edge register still tracks input).
REQ-020 SHALL load hold timer with RESTART_HOLD on PLAY->OVER and decrement to 0 each OVER cycle; start_i ignored while nonzero; RESTART_HOLD=0 means start accepted in first OVER cycle.
REQ-021 SHALL compare live score to high score (BCD, d3 most significant) on the edge ending the first OVER cycle, loading high score and setting new_high_o only if strictly greater.
REQ-022 SHALL hold new_high_o until OVER->IDLE; clear it on that transition.
REQ-023 SHALL retain high score across games; only rst_ni clears it.

Reset
REQ-024 SHALL on rst_ni=0 immediately force: state IDLE, score_en_o=0, score_rst_no=0, hi digits 0, new_high_o=0, timer 0, edge register 0.
REQ-025 SHALL abandon a game in progress on reset mid-PLAY/OVER with no pending score_en_o pulse emitted after release.

Configuration
REQ-026 SHALL implement high-score tracking (REQ-021..023) only when SCORE_CTRL_HISCORE_EN is defined.
REQ-027 SHALL, without SCORE_CTRL_HISCORE_EN, tie hi_d0_o..hi_d3_o and new_high_o to 0 and instantiate no high-score registers; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, start_i pulse, 3 single-cycle pipe pulses -> 3 score_en_o pulses each one cycle after its pipe pulse; state_o=1.
REQ-029 SHALL cover: pipe_passed_i held 20 cycles in PLAY -> exactly one score_en_o pulse.
REQ-030 SHALL cover: pipe edge and collision_i same cycle at score 0042 -> no score_en_o, state_o=2 next cycle, score stays 0042.
REQ-031 SHALL cover: score inputs 9999 plus pipe edge -> no score_en_o.
REQ-032 SHALL cover: RESTART_HOLD=4, game ends at 0017 with high 0012 -> hi=0017, new_high_o=1; start_i at OVER cycles 1..3 ignored, at cycle 5 -> IDLE, score_rst_no=0, new_high_o=0; next game ending 0005 keeps hi=0017.
REQ-033 SHALL cover: rst_ni asserted mid-PLAY asynchronously (between edges) -> outputs reset values before next clock edge; build without SCORE_CTRL_HISCORE_EN -> hi digits and new_high_o constant 0.
